// File: rtl/par2ser_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : par2ser_shifter_pkg
// Brief    : State encodings and bit-order selectors for par2ser_shifter.
// Revision : 1.0 - initial release
// ============================================================================
package par2ser_shifter_pkg;

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_SHIFT = 2'b01;
    localparam logic [1:0] c_DONE  = 2'b10;

    localparam bit c_MSB_FIRST = 1'b0;
    localparam bit c_LSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/par2ser_shifter_dff_r_sync.sv
`default_nettype none
// ============================================================================
// Module   : par2ser_shifter_dff_r_sync (+ par2ser_shifter_and2, _dlatch)
// Brief    : Rising-edge D flip-flop with synchronous active-low reset, built
//            as a master/slave pair of D latches.
// Revision : 1.0 - initial release
// ============================================================================
module par2ser_shifter_and2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

module par2ser_shifter_dlatch #(
    parameter bit EN_HIGH = 1'b1
) (
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);
    logic r_q;

    // Enable polarity is a parameter so both latches of a flop see clk directly.
    always_latch begin
        if (i_en == EN_HIGH) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

module par2ser_shifter_dff_r_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic w_d_gated;
    logic w_master;

    par2ser_shifter_and2 u_rst_gate (
        .i_a (i_d),
        .i_b (reset_n),
        .o_y (w_d_gated)
    );

    par2ser_shifter_dlatch #(.EN_HIGH(1'b0)) u_master (
        .i_en (clk),
        .i_d  (w_d_gated),
        .o_q  (w_master)
    );

    par2ser_shifter_dlatch #(.EN_HIGH(1'b1)) u_slave (
        .i_en (clk),
        .i_d  (w_master),
        .o_q  (o_q)
    );
endmodule
`default_nettype wire

// File: rtl/par2ser_shifter.sv
`default_nettype none
// ============================================================================
// Module   : par2ser_shifter
// Brief    : Parallel-to-serial converter with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module par2ser_shifter
    import par2ser_shifter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = c_MSB_FIRST
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] d_in,
    output logic             s_out,
    output logic             s_valid,
    output logic             busy,
    output logic             done
);
    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_shreg;

    wire logic               w_in_idle;
    wire logic               w_in_shift;
    wire logic               w_in_done;
    wire logic               w_cnt_zero;
    wire logic               w_load;
    wire logic               w_step;
    wire logic               w_out_bit;
    wire logic [WIDTH-1:0]   w_shreg_shifted;
    wire logic [1:0]         w_state_nxt;
    wire logic [c_CNT_W-1:0] w_cnt_nxt;
    wire logic [WIDTH-1:0]   w_shreg_nxt;

    assign w_in_idle  = (r_state == c_IDLE);
    assign w_in_shift = (r_state == c_SHIFT);
    assign w_in_done  = (r_state == c_DONE);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_load     = w_in_idle & start;
    assign w_step     = w_in_shift & ~abort;

    generate
        if (LSB_FIRST == c_LSB_FIRST) begin : g_lsb_first
            assign w_shreg_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit       = r_shreg[0];
        end else begin : g_msb_first
            assign w_shreg_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit       = r_shreg[WIDTH-1];
        end
    endgenerate

    // Anything not explicitly held or loaded (abort, illegal 2'b11) falls to IDLE/zero.
    assign w_state_nxt = w_load ? c_SHIFT
                       : w_step ? (w_cnt_zero ? c_DONE : c_SHIFT)
                       : c_IDLE;

    assign w_cnt_nxt = w_load                    ? c_CNT_LOAD
                     : (w_step & ~w_cnt_zero)    ? r_cnt - c_CNT_W'(1)
                     : (w_in_idle | w_in_done)   ? r_cnt
                     : '0;

    assign w_shreg_nxt = w_load                  ? d_in
                       : w_step                  ? w_shreg_shifted
                       : (w_in_idle | w_in_done) ? r_shreg
                       : '0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_state
            par2ser_shifter_dff_r_sync u_ff (
                .clk     (clk),
                .reset_n (reset_n),
                .i_d     (w_state_nxt[gi]),
                .o_q     (r_state[gi])
            );
        end

        for (genvar gi = 0; gi < c_CNT_W; gi++) begin : g_cnt
            par2ser_shifter_dff_r_sync u_ff (
                .clk     (clk),
                .reset_n (reset_n),
                .i_d     (w_cnt_nxt[gi]),
                .o_q     (r_cnt[gi])
            );
        end

        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shreg
            par2ser_shifter_dff_r_sync u_ff (
                .clk     (clk),
                .reset_n (reset_n),
                .i_d     (w_shreg_nxt[gi]),
                .o_q     (r_shreg[gi])
            );
        end
    endgenerate

    assign s_out   = w_in_shift & w_out_bit;
    assign s_valid = w_in_shift;
    assign busy    = w_in_shift | w_in_done;
    assign done    = w_in_done;

endmodule
`default_nettype wire

// File: tb/tb_par2ser_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_par2ser_shifter
// Brief    : Directed + random bench for three par2ser_shifter configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_par2ser_shifter;
    import par2ser_shifter_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] d_in8;
    logic [1:0] d_in2;

    logic so0, sv0, bz0, dn0;
    logic so1, sv1, bz1, dn1;
    logic so2, sv2, bz2, dn2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: 0 idle, 1 sending, 2 done, 3 illegal
    int m_mode [3];
    int m_pos  [3];
    int m_len  [3];
    bit m_seq  [3][32];

    logic [7:0] cap;

    par2ser_shifter #(.WIDTH(8), .LSB_FIRST(c_MSB_FIRST)) dut_m8 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .d_in(d_in8),
        .s_out(so0), .s_valid(sv0), .busy(bz0), .done(dn0)
    );

    par2ser_shifter #(.WIDTH(8), .LSB_FIRST(c_LSB_FIRST)) dut_l8 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .d_in(d_in8),
        .s_out(so1), .s_valid(sv1), .busy(bz1), .done(dn1)
    );

    par2ser_shifter #(.WIDTH(2), .LSB_FIRST(c_MSB_FIRST)) dut_m2 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .d_in(d_in2),
        .s_out(so2), .s_valid(sv2), .busy(bz2), .done(dn2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int width_of(input int k);
        return (k == 2) ? 2 : 8;
    endfunction

    function automatic bit lsb_of(input int k);
        return (k == 1);
    endfunction

    task automatic model_edge();
        logic [31:0] word;
        for (int k = 0; k < 3; k++) begin
            word = (k == 2) ? 32'(d_in2) : 32'(d_in8);
            if (!reset_n) begin
                m_mode[k] = 0;
            end else begin
                case (m_mode[k])
                    0: if (start) begin
                        m_len[k] = width_of(k);
                        for (int i = 0; i < m_len[k]; i++)
                            m_seq[k][i] = lsb_of(k) ? word[i] : word[m_len[k] - 1 - i];
                        m_pos[k]  = 0;
                        m_mode[k] = 1;
                    end
                    1: if (abort) begin
                        m_mode[k] = 0;
                    end else begin
                        m_pos[k]++;
                        if (m_pos[k] == m_len[k]) m_mode[k] = 2;
                    end
                    default: m_mode[k] = 0;
                endcase
            end
        end
    endtask

    // Packed as {s_out, s_valid, busy, done}
    function automatic logic [3:0] model_out(input int k);
        logic s;
        s = (m_mode[k] == 1) ? m_seq[k][m_pos[k]] : 1'b0;
        return {s, m_mode[k] == 1, (m_mode[k] == 1) || (m_mode[k] == 2), m_mode[k] == 2};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check($sformatf("m8_cyc%0d", cyc), 32'({so0, sv0, bz0, dn0}), 32'(model_out(0)));
        check($sformatf("l8_cyc%0d", cyc), 32'({so1, sv1, bz1, dn1}), 32'(model_out(1)));
        check($sformatf("m2_cyc%0d", cyc), 32'({so2, sv2, bz2, dn2}), 32'(model_out(2)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check_all();
    endtask

    // Collects eight serial bits from the MSB-first 8-bit unit, first bit already visible.
    task automatic capture8(output logic [7:0] c);
        c = {7'd0, so0};
        for (int i = 0; i < 7; i++) begin
            tick();
            c = {c[6:0], so0};
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_mode[k] = 0;
            m_pos[k]  = 0;
            m_len[k]  = 0;
        end
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        d_in8   = 8'h00;
        d_in2   = 2'b00;

        // Reset state
        tick();
        tick();

        // Basic transfer: A5 on the 8-bit units, 2'b10 on the 2-bit unit
        reset_n = 1'b1;
        d_in8   = 8'hA5;
        d_in2   = 2'b10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        d_in8 = 8'h00;
        capture8(cap);
        check("a5_serial_msb", 32'(cap), 32'h0000_00A5);
        repeat (3) tick();

        // LSB-first single set bit
        d_in8 = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();

        // start held high, d_in changes mid-transfer
        d_in8 = 8'hF0;
        d_in2 = 2'b01;
        start = 1'b1;
        tick();
        d_in8 = 8'h0F;
        capture8(cap);
        check("held_start_first_word", 32'(cap), 32'h0000_00F0);
        tick();
        tick();
        tick();
        capture8(cap);
        check("held_start_second_word", 32'(cap), 32'h0000_000F);
        start = 1'b0;
        repeat (3) tick();

        // Abort during the third bit, then a fresh start
        d_in8 = 8'hFF;
        d_in2 = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        d_in8 = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();

        // Reset during the fifth bit; a between-edge pulse must not disturb anything
        d_in8 = 8'h5A;
        d_in2 = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        #6;
        check_all();
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Illegal state 2'b11 on the 2-bit unit
        d_in2 = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        force dut_m2.w_state_nxt = 2'b11;
        @(posedge clk);
        model_edge();
        #1;
        release dut_m2.w_state_nxt;
        m_mode[2] = 3;
        cyc++;
        check_all();
        tick();
        d_in2 = 2'b01;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            start   = ($urandom_range(2) == 0);
            abort   = ($urandom_range(15) == 0);
            reset_n = ($urandom_range(39) != 0);
            d_in8   = 8'($urandom);
            d_in2   = 2'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
